// File: rtl/prm_pkg.sv
// Shared types for the PRM edge-verdict path: sample code width, accumulator
// states and the per-edge result payload.
package prm_pkg;

    localparam int unsigned PRM_CODE_W = 15;
    localparam int unsigned PRM_ID_W   = 8;
    localparam int unsigned PRM_CNT_W  = 8;
    localparam int unsigned PRM_CIDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } prm_state_e;

    typedef struct packed {
        logic [PRM_ID_W-1:0]   id;
        logic                  blocked;
        logic [PRM_CNT_W-1:0]  first_idx;
        logic [PRM_CIDX_W-1:0] chk_idx;
        logic [PRM_CNT_W-1:0]  nsamp;
    } prm_edge_res_t;

endpackage

// File: rtl/prm_prio_enc.sv
// Lowest-set-bit priority encoder; idx_c is 0 when no bit is set.
module prm_prio_enc
    import prm_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     bits,
    output logic [IDX_W-1:0] idx_c
);

    // Scan from the top so the lowest set bit is written last and wins.
    always_comb begin
        idx_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/prm_edge_mask_acc.sv
// Registers samples onto the checker code bus and folds the returned hit masks
// into one blocked/first-hit/count verdict per edge on a valid/ready channel.
module prm_edge_mask_acc
    import prm_pkg::*;
#(
    parameter int unsigned NCHK  = 8,
    parameter int unsigned ID_W  = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PRM_CODE_W-1:0]   s_code,
    input  logic [ID_W-1:0]         s_id,
    input  logic                    s_last,
    output logic [PRM_CODE_W-1:0]   chk_code,
    input  logic [NCHK-1:0]         chk_mask,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [ID_W-1:0]         r_id,
    output logic                    r_blocked,
    output logic [CNT_W-1:0]        r_first_idx,
    output logic [$clog2(NCHK)-1:0] r_chk_idx,
    output logic [CNT_W-1:0]        r_nsamp,
    output logic                    err
);

    localparam int unsigned    CIDX_W  = $clog2(NCHK);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              v1_q;
    logic              last1_q;
    logic [ID_W-1:0]   id1_q;

    prm_state_e        state_q, state_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  first_idx_q, first_idx_d;
    logic [CIDX_W-1:0] chk_idx_q, chk_idx_d;
    logic              blk_q, blk_d;
    prm_edge_res_t     res_q, res_d;
    logic              r_valid_d;
    logic              err_d;

    logic              mismatch_c;
    logic              close_c;
    logic              stall_c;
    logic              fire1_c;
    logic              hit_c;
    logic [CNT_W-1:0]  idx_c;
    logic [CIDX_W-1:0] enc_idx_c;

    prm_prio_enc #(
        .N     (NCHK),
        .IDX_W (CIDX_W)
    ) u_enc (
        .bits  (chk_mask),
        .idx_c (enc_idx_c)
    );

    // An edge closes on its last sample or on a foreign id; either needs a free result slot.
    always_comb begin
        mismatch_c = v1_q & (state_q == OPEN) & (id1_q != cur_id_q);
        close_c    = last1_q | mismatch_c;
        stall_c    = v1_q & close_c & r_valid & ~r_ready;
        s_ready    = ~stall_c;
        fire1_c    = v1_q & ~stall_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            id1_q    <= '0;
            chk_code <= '0;
        end else if (!stall_c) begin
            v1_q <= s_valid;
            if (s_valid) begin
                chk_code <= s_code;
                id1_q    <= s_id;
                last1_q  <= s_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_id_q    <= '0;
            cnt_q       <= '0;
            first_idx_q <= '0;
            chk_idx_q   <= '0;
            blk_q       <= 1'b0;
            res_q       <= '0;
            r_valid     <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            cnt_q       <= cnt_d;
            first_idx_q <= first_idx_d;
            chk_idx_q   <= chk_idx_d;
            blk_q       <= blk_d;
            res_q       <= res_d;
            r_valid     <= r_valid_d;
            err         <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        cnt_d       = cnt_q;
        first_idx_d = first_idx_q;
        chk_idx_d   = chk_idx_q;
        blk_d       = blk_q;
        res_d       = res_q;
        err_d       = err;
        r_valid_d   = r_valid & ~r_ready;
        hit_c       = |chk_mask;
        idx_c       = (state_q == IDLE) ? '0 : cnt_q;

        if (fire1_c) begin
            if (mismatch_c) begin
                // Truncated edge: report blocked with the partial count, drop this sample.
                res_d.id        = PRM_ID_W'(cur_id_q);
                res_d.blocked   = 1'b1;
                res_d.first_idx = PRM_CNT_W'(cnt_q);
                res_d.chk_idx   = PRM_CIDX_W'(chk_idx_q);
                res_d.nsamp     = PRM_CNT_W'(cnt_q);
                r_valid_d       = 1'b1;
                err_d           = 1'b1;
                state_d         = IDLE;
            end else begin
                if (state_q == IDLE) begin
                    cur_id_d    = id1_q;
                    blk_d       = 1'b0;
                    first_idx_d = '0;
                    chk_idx_d   = '0;
                end
                if (hit_c && !blk_d) begin
                    first_idx_d = idx_c;
                    chk_idx_d   = enc_idx_c;
                end
                blk_d = blk_d | hit_c;
                cnt_d = (idx_c == CNT_MAX) ? CNT_MAX : idx_c + CNT_W'(1);
                if (last1_q) begin
                    res_d.id        = PRM_ID_W'(cur_id_d);
                    res_d.blocked   = blk_d;
                    res_d.first_idx = PRM_CNT_W'(first_idx_d);
                    res_d.chk_idx   = PRM_CIDX_W'(chk_idx_d);
                    res_d.nsamp     = PRM_CNT_W'(cnt_d);
                    r_valid_d       = 1'b1;
                    state_d         = IDLE;
                end else begin
                    state_d = OPEN;
                end
            end
        end
    end

    assign r_id        = ID_W'(res_q.id);
    assign r_blocked   = res_q.blocked;
    assign r_first_idx = CNT_W'(res_q.first_idx);
    assign r_chk_idx   = CIDX_W'(res_q.chk_idx);
    assign r_nsamp     = CNT_W'(res_q.nsamp);

endmodule

// File: tb/tb_prm_edge_mask_acc.sv
// Scoreboard bench for prm_edge_mask_acc: edge-level reference model feeds an
// expected-result queue, a monitor pops and compares on every result handshake.
module tb_prm_edge_mask_acc;

    localparam int unsigned NCHK   = 8;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int          BUDGET = 2000;

    typedef struct {
        logic [7:0] id;
        logic       blocked;
        logic [7:0] first;
        logic [2:0] ck;
        logic [7:0] nsamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid;
    logic        s_ready;
    logic [14:0] s_code;
    logic [7:0]  s_id;
    logic        s_last;
    logic [14:0] chk_code;
    logic [7:0]  chk_mask;
    logic        r_valid;
    logic        r_ready;
    logic [7:0]  r_id;
    logic        r_blocked;
    logic [7:0]  r_first_idx;
    logic [2:0]  r_chk_idx;
    logic [7:0]  r_nsamp;
    logic        err;

    exp_t        sbq[$];
    logic [14:0] ecodes[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          rdy_mode = 0;

    always #5 clk = ~clk;

    prm_edge_mask_acc #(
        .NCHK  (NCHK),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_code      (s_code),
        .s_id        (s_id),
        .s_last      (s_last),
        .chk_code    (chk_code),
        .chk_mask    (chk_mask),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_id        (r_id),
        .r_blocked   (r_blocked),
        .r_first_idx (r_first_idx),
        .r_chk_idx   (r_chk_idx),
        .r_nsamp     (r_nsamp),
        .err         (err)
    );

    // Stand-in checker bank: checker j hits when code bit 14 and code bit j are both set.
    function automatic logic [7:0] bank(input logic [14:0] c);
        return c[14] ? c[7:0] : 8'h00;
    endfunction

    assign chk_mask = bank(chk_code);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t model_edge(input logic [7:0] id);
        exp_t       e;
        logic [7:0] m;
        logic       found;
        e.id      = id;
        e.blocked = 1'b0;
        e.first   = 8'd0;
        e.ck      = 3'd0;
        e.nsamp   = (ecodes.size() > 255) ? 8'd255 : 8'(ecodes.size());
        for (int i = 0; i < ecodes.size(); i++) begin
            m = bank(ecodes[i]);
            if (m != 8'h00 && !e.blocked) begin
                e.blocked = 1'b1;
                e.first   = (i > 255) ? 8'd255 : 8'(i);
                found     = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    if (m[j] && !found) begin
                        e.ck  = 3'(j);
                        found = 1'b1;
                    end
                end
            end
        end
        return e;
    endfunction

    // Result-side backpressure: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        r_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       r_ready = 1'b1;
                1:       r_ready = 1'($urandom_range(0, 1));
                default: r_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare on each result handshake, and check payload stays put while stalled.
    initial begin
        exp_t       e;
        logic       held = 1'b0;
        logic [7:0] p_id, p_first, p_nsamp;
        logic       p_blk;
        logic [2:0] p_ck;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", 32'(r_valid), 32'd1);
                    chk("hold_payload", {r_id, r_blocked, r_first_idx, r_chk_idx, r_nsamp, 4'h0},
                        {p_id, p_blk, p_first, p_ck, p_nsamp, 4'h0});
                end
                if (r_valid && r_ready) begin
                    held = 1'b0;
                    chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("r_id", 32'(r_id), 32'(e.id));
                        chk("r_blocked", 32'(r_blocked), 32'(e.blocked));
                        chk("r_first_idx", 32'(r_first_idx), 32'(e.first));
                        chk("r_chk_idx", 32'(r_chk_idx), 32'(e.ck));
                        chk("r_nsamp", 32'(r_nsamp), 32'(e.nsamp));
                    end
                end else if (r_valid) begin
                    held    = 1'b1;
                    p_id    = r_id;
                    p_blk   = r_blocked;
                    p_first = r_first_idx;
                    p_ck    = r_chk_idx;
                    p_nsamp = r_nsamp;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    task automatic send_sample(input logic [14:0] code, input logic [7:0] id, input logic last);
        logic hs;
        s_valid = 1'b1;
        s_code  = code;
        s_id    = id;
        s_last  = last;
        hs      = 1'b0;
        for (int k = 0; k < BUDGET && !hs; k++) begin
            @(negedge clk);
            hs = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!hs) chk("s_handshake_timeout", 32'd0, 32'd1);
        else chk("chk_code", 32'(chk_code), 32'(code));
    endtask

    task automatic send_edge(input logic [7:0] id);
        sbq.push_back(model_edge(id));
        for (int i = 0; i < ecodes.size(); i++) begin
            send_sample(ecodes[i], id, i == ecodes.size() - 1);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < BUDGET && sbq.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic chk_reset_state();
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_chk_code", 32'(chk_code), 32'd0);
        chk("rst_payload", {8'h0, r_id, r_blocked, r_first_idx, r_chk_idx, r_nsamp, 4'h0}, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   n;
        s_valid = 1'b0;
        s_code  = '0;
        s_id    = '0;
        s_last  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three clean samples, id 5, with latency check.
        ecodes = {15'h0123, 15'h0abc, 15'h3fff};
        send_edge(8'd5);
        @(negedge clk);
        chk("lat_one_cycle", 32'(r_valid), 32'd0);
        @(negedge clk);
        chk("lat_two_cycles", 32'(r_valid), 32'd1);
        @(posedge clk);
        #1;
        wait_drain();

        // First hit on sample 1 at checker 2; later hit ignored.
        ecodes = {15'h0000, 15'h4024, 15'h0000, 15'h4001};
        send_edge(8'd9);
        wait_drain();

        // Back-to-back single-sample edges under held-low r_ready.
        rdy_mode = 2;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        ecodes = {15'h0000};
        send_edge(8'd1);
        send_edge(8'd2);
        sbq.push_back(model_edge(8'd3));
        s_valid = 1'b1;
        s_code  = 15'h0000;
        s_id    = 8'd3;
        s_last  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_s_ready", 32'(s_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        send_sample(15'h0000, 8'd3, 1'b1);
        wait_drain();

        // 300-sample edge: count saturates.
        rdy_mode = 1;
        ecodes.delete();
        for (int i = 0; i < 300; i++) begin
            ecodes.push_back((i == 10) ? 15'h4080 : 15'($urandom) & 15'h3fff);
        end
        send_edge(8'h2a);
        wait_drain();

        // Id change inside an open edge.
        rdy_mode = 0;
        chk("err_before_mismatch", 32'(err), 32'd0);
        e.id = 8'd4; e.blocked = 1'b1; e.first = 8'd2; e.ck = 3'd0; e.nsamp = 8'd2;
        sbq.push_back(e);
        send_sample(15'h0011, 8'd4, 1'b0);
        send_sample(15'h0022, 8'd4, 1'b0);
        send_sample(15'h40ff, 8'd7, 1'b0);
        ecodes = {15'h4002};
        send_edge(8'd7);
        wait_drain();
        chk("err_after_mismatch", 32'(err), 32'd1);

        // Random edges with random backpressure.
        rdy_mode = 1;
        for (int t = 0; t < 40; t++) begin
            ecodes.delete();
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                ecodes.push_back(($urandom_range(0, 5) == 0) ? (15'h4000 | 15'($urandom_range(1, 255)))
                                                              : 15'($urandom) & 15'h3fff);
            end
            send_edge(8'($urandom));
        end
        wait_drain();

        // Reset mid-edge with a pending result.
        rdy_mode = 2;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        ecodes = {15'h4004, 15'h0000};
        send_edge(8'h11);
        send_sample(15'h4001, 8'h22, 1'b0);
        send_sample(15'h4001, 8'h22, 1'b0);
        @(negedge clk);
        chk("pre_reset_r_valid", 32'(r_valid), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state();
        sbq.delete();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ecodes = {15'h4010};
        send_edge(8'h22);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
